if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, drives the instruction-memory address and computes PC+4. It also owns the IF/ID pipeline register. It consumes the stall from the ID hazard unit and the branch/jump redirect resolved in ID, and it feeds the instruction, PC+4 and a valid flag to the decode stage.

Parameters:
PC_WIDTH, 32, width of PC and address buses
INSTR_WIDTH, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_INSTR, 32'h0000_0000, instruction inserted into IF/ID on bubble (sll $0,$0,0)

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
i_stall  in  1  hazard-unit stall; freezes PC and IF/ID
i_branch_taken  in  1  branch resolved taken in ID
i_branch_target  in  PC_WIDTH  branch destination
i_jump  in  1  J/JAL/JR resolved in ID
i_jump_target  in  PC_WIDTH  jump destination
i_halt  in  1  halt request from debug unit; stops fetch
o_imem_addr  out  PC_WIDTH  instruction memory address (= current PC, combinational)
i_imem_rdata  in  INSTR_WIDTH  instruction read data (asynchronous read, same cycle)
o_instr_id  out  INSTR_WIDTH  IF/ID instruction
o_pc_plus4_id  out  PC_WIDTH  IF/ID PC+4 of that instruction
o_valid_id  out  1  IF/ID holds a real instruction (0 = bubble)
o_pc  out  PC_WIDTH  current fetch PC (debug visibility)

Behaviour:
- Reset (sampled on clk edge while reset=1) sets the following:
  - PC=RESET_PC.
  - o_instr_id=NOP_INSTR, o_pc_plus4_id=0, o_valid_id=0.
  - reset dominates every other input.
- o_imem_addr = o_pc = PC, combinational from the PC register. No extra latency.
- pc_plus4 = PC + 4, modulo 2^PC_WIDTH. Wrap-around from 32'hFFFF_FFFC gives 0; no error is flagged.
- Redirect target: jump target if i_jump=1, else branch target if i_branch_taken=1. Bits [1:0] of the selected target are forced to 0.
- There is no branch delay slot.
- Per-edge update priority, highest first:
  1. reset: as above.
  2. i_stall=1: PC and all IF/ID registers hold their values. i_branch_taken, i_jump and i_halt are ignored this cycle, because the branch operands are not yet valid.
  3. redirect (i_jump or i_branch_taken) with i_stall=0: PC <= target. IF/ID is loaded with a bubble (o_instr_id=NOP_INSTR, o_valid_id=0, o_pc_plus4_id=0), which squashes the wrong-path instruction. A redirect overrides i_halt in the same cycle.
  4. i_halt=1: PC holds. IF/ID is loaded with a bubble, so no new instruction enters decode while halted.
  5. normal: PC <= pc_plus4. IF/ID <= {i_imem_rdata, pc_plus4}, o_valid_id=1.
- Simultaneous i_jump and i_branch_taken: jump wins.
- Latency:
  - The instruction at PC appears on o_instr_id one edge after PC presents it.
  - After a redirect edge, the target instruction reaches IF/ID on the following edge, giving a 1-cycle penalty.
- Stall duration is unbounded. The IF/ID contents and PC are held bit-exact throughout the stall.
- Reset asserted mid-stall or mid-halt returns to the reset state in one edge. The first valid instruction appears in IF/ID on the first non-stalled edge after reset deasserts.
- Internal state is only the PC register and the IF/ID register set. No FSM beyond the priority selection above.

Test Plan:
- Reset then free-run: reset high 2 cycles, then low, with imem returning addr-tagged words. Required response:
  - o_imem_addr = 0x0, 0x4, 0x8 …
  - o_valid_id=0 until the first edge after deassert.
  - Then o_instr_id = word@0 with o_pc_plus4_id=0x4, followed by word@4 with 0x8.
- Stall hold: at PC=0x10, assert i_stall for 3 cycles. Required response:
  - PC stays 0x10 and o_instr_id/o_pc_plus4_id (word@0xC/0x10) are unchanged for those 3 cycles.
  - On release, PC=0x14 and IF/ID=word@0x10.
- Branch redirect: at PC=0x20, pulse i_branch_taken with target 0x103. Required response:
  - Next PC=0x100 (low bits masked) and IF/ID becomes a bubble (valid=0, NOP).
  - The next edge gives IF/ID=word@0x100, pc_plus4=0x104.
- Stall beats redirect: i_stall=1 with i_jump=1 and target 0x200. Required response: PC is unchanged and no bubble is inserted. Dropping the stall while keeping the jump gives PC=0x200.
- Jump vs branch and halt: i_jump (0x300), i_branch_taken (0x400) and i_halt all high together. Required response: PC=0x300 and IF/ID is a bubble.
- Halt alone for 2 cycles holds PC and gives 2 bubbles. Reset asserted during the halt gives PC=RESET_PC.
- Wrap-around: force PC=0xFFFF_FFFC via jump and free-run. Required response: next PC=0x0, and o_pc_plus4_id=0x0 for that instruction.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+4, redirect/stall/halt selection
// and the IF/ID pipeline register feeding decode.
module if_stage #(
  parameter int                      PC_WIDTH    = 32,
  parameter int                      INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = 32'h0000_0000,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_stall,
  input  logic                   i_branch_taken,
  input  logic [PC_WIDTH-1:0]    i_branch_target,
  input  logic                   i_jump,
  input  logic [PC_WIDTH-1:0]    i_jump_target,
  input  logic                   i_halt,
  output logic [PC_WIDTH-1:0]    o_imem_addr,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic [INSTR_WIDTH-1:0] o_instr_id,
  output logic [PC_WIDTH-1:0]    o_pc_plus4_id,
  output logic                   o_valid_id,
  output logic [PC_WIDTH-1:0]    o_pc
);

  logic [PC_WIDTH-1:0]    pc_reg, pc_next;
  logic [PC_WIDTH-1:0]    pc_plus4;
  logic [PC_WIDTH-1:0]    target_raw, redirect_target;
  logic                   redirect;
  logic [INSTR_WIDTH-1:0] instr_id_reg, instr_id_next;
  logic [PC_WIDTH-1:0]    pc_plus4_id_reg, pc_plus4_id_next;
  logic                   valid_id_reg, valid_id_next;

  assign pc_plus4        = pc_reg + PC_WIDTH'(4);
  assign redirect        = i_jump | i_branch_taken;
  assign target_raw      = i_jump ? i_jump_target : i_branch_target;
  assign redirect_target = {target_raw[PC_WIDTH-1:2], 2'b00};

  // Stall beats redirect (branch operands not ready), redirect beats halt.
  always_comb begin
    pc_next          = pc_reg;
    instr_id_next    = instr_id_reg;
    pc_plus4_id_next = pc_plus4_id_reg;
    valid_id_next    = valid_id_reg;
    if (!i_stall) begin
      if (redirect) begin
        pc_next          = redirect_target;
        instr_id_next    = NOP_INSTR;
        pc_plus4_id_next = '0;
        valid_id_next    = 1'b0;
      end else if (i_halt) begin
        instr_id_next    = NOP_INSTR;
        pc_plus4_id_next = '0;
        valid_id_next    = 1'b0;
      end else begin
        pc_next          = pc_plus4;
        instr_id_next    = i_imem_rdata;
        pc_plus4_id_next = pc_plus4;
        valid_id_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      instr_id_reg    <= NOP_INSTR;
      pc_plus4_id_reg <= '0;
      valid_id_reg    <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      instr_id_reg    <= instr_id_next;
      pc_plus4_id_reg <= pc_plus4_id_next;
      valid_id_reg    <= valid_id_next;
    end
  end

  assign o_imem_addr   = pc_reg;
  assign o_pc          = pc_reg;
  assign o_instr_id    = instr_id_reg;
  assign o_pc_plus4_id = pc_plus4_id_reg;
  assign o_valid_id    = valid_id_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: reference model pushes expected PC/IF-ID state into a
// scoreboard queue each cycle; entries are popped and compared after the edge.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_stall, i_branch_taken, i_jump, i_halt;
  logic [31:0] i_branch_target, i_jump_target;
  logic [31:0] o_imem_addr, i_imem_rdata, o_instr_id, o_pc_plus4_id, o_pc;
  logic        o_valid_id;

  always #5 clk = ~clk;

  if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .i_stall         (i_stall),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_halt          (i_halt),
    .o_imem_addr     (o_imem_addr),
    .i_imem_rdata    (i_imem_rdata),
    .o_instr_id      (o_instr_id),
    .o_pc_plus4_id   (o_pc_plus4_id),
    .o_valid_id      (o_valid_id),
    .o_pc            (o_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_0000;
  endfunction

  // Asynchronous-read instruction memory with address-tagged contents.
  assign i_imem_rdata = mem_word(o_imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic        m_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step(input string tag, input logic rst, input logic stall,
                      input logic br, input logic [31:0] bt,
                      input logic jmp, input logic [31:0] jt, input logic halt);
    exp_t e;
    @(negedge clk);
    reset = rst; i_stall = stall; i_branch_taken = br; i_branch_target = bt;
    i_jump = jmp; i_jump_target = jt; i_halt = halt;
    #1;
    if (m_known) check({tag, ":imem_addr"}, o_imem_addr, m_pc);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (jmp || br) begin
      m_pc = (jmp ? jt : bt) & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else if (halt) begin
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
    end
    m_known = 1'b1;
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ":pc"}, o_pc, e.pc);
    check({tag, ":instr_id"}, o_instr_id, e.instr);
    check({tag, ":pc_plus4_id"}, o_pc_plus4_id, e.pc4);
    check({tag, ":valid_id"}, {31'b0, o_valid_id}, {31'b0, e.valid});
    $display("[%s] rst=%0b stall=%0b br=%0b jmp=%0b halt=%0b -> pc=%h id=%h pc4=%h v=%0b",
             tag, rst, stall, br, jmp, halt, o_pc, o_instr_id, o_pc_plus4_id, o_valid_id);
  endtask

  task automatic run(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; i_stall = 1'b0; i_branch_taken = 1'b0; i_jump = 1'b0;
    i_halt = 1'b0; i_branch_target = '0; i_jump_target = '0;

    // Reset then free-run
    step("reset0", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("reset1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("reset_valid_const", {31'b0, o_valid_id}, 32'h0);
    run("run0");
    check("first_pc4_const", o_pc_plus4_id, 32'h4);
    run("run1");
    run("run2");
    run("run3");
    check("pc_at_0x10_const", o_pc, 32'h10);

    // Stall hold for 3 cycles, then release
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    check("stall_id_const", o_instr_id, mem_word(32'hC));
    run("release");
    check("release_pc_const", o_pc, 32'h14);
    run("run4");
    run("run5");
    run("run6");

    // Branch redirect with unaligned target
    step("branch", 1'b0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 1'b0);
    check("branch_pc_const", o_pc, 32'h100);
    run("after_branch");
    check("after_branch_pc4_const", o_pc_plus4_id, 32'h104);

    // Stall beats redirect
    step("stall_jump", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    step("jump", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    check("jump_pc_const", o_pc, 32'h200);

    // Jump beats branch beats halt
    step("jmp_br_halt", 1'b0, 1'b0, 1'b1, 32'h400, 1'b1, 32'h300, 1'b1);
    check("jmp_win_pc_const", o_pc, 32'h300);
    run("run7");

    // Halt for 2 cycles, then reset during halt
    step("halt0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("halt1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    step("reset_halt", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    run("run8");
    run("run9");

    // Wrap-around from the top of the address space
    step("jump_top", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    run("wrap");
    check("wrap_pc_const", o_pc, 32'h0);
    check("wrap_pc4_const", o_pc_plus4_id, 32'h0);
    run("run10");

    // Random mix of controls
    for (int i = 0; i < 60; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0), $urandom(),
           ($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 5) == 0));
    end

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
